// File: rtl/rejunity_ternary_dot.sv
// rejunity_ternary_dot
//   Streaming ternary-weight dot-product engine in a Tiny Tapeout user tile.
//   The host shifts in sixteen 2-bit weights, four per byte. It then streams
//   signed 8-bit activations. Each activation is multiplied by the next weight
//   in round-robin order and added into a 14-bit signed accumulator.
//
// Optional feature (compile-time macro):
//   TERNARY_DOT_SATURATE_EN  defined   -> the accumulator clamps to [-8192, 8191]
//                            undefined -> the accumulator wraps in two's complement
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (overrides ena and cmd)
//   ena      tile enable; when low, all state holds
//   ui_in    packed weights (LOAD) or signed activation (ACC)
//   uio_in   [1:0] = command: 00 IDLE, 01 LOAD, 10 ACC, 11 CLEAR; [7:2] ignored
//   uo_out   acc[7:0]
//   uio_out  {acc[13:8], 2'b00}
//   uio_oe   constant 8'hFC (upper six pins are outputs)
module rejunity_ternary_dot (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_ACC   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  logic [31:0]        wreg;
  logic [3:0]         ptr;
  logic signed [13:0] acc;

  logic [1:0]         cmd;
  logic [1:0]         wsel;
  logic signed [14:0] act_ext;
  logic signed [14:0] prod;
  logic signed [14:0] sum;
  logic signed [13:0] acc_next;

  // The upper uio_in bits are not part of the command.
  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:2]};

  assign cmd     = uio_in[1:0];
  assign wsel    = wreg[{ptr, 1'b0} +: 2];
  assign act_ext = {{7{ui_in[7]}}, ui_in};

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    prod = '0;
    case (wsel)
      2'b01:   prod = act_ext;
      2'b11:   prod = -act_ext;  // -(-128) = +128 fits in 15 bits
      default: prod = '0;        // 00 and 10 both decode to zero
    endcase

    // One guard bit above the accumulator catches any overflow of the add.
    sum = {acc[13], acc} + prod;

`ifdef TERNARY_DOT_SATURATE_EN
    // Overflow shows up as the guard bit disagreeing with the 14-bit sign.
    if (sum[14] != sum[13]) begin
      acc_next = sum[14] ? 14'sh2000 : 14'sh1FFF;
    end else begin
      acc_next = sum[13:0];
    end
`else
    acc_next = sum[13:0];
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (rst) begin
      wreg <= '0;
      ptr  <= '0;
      acc  <= '0;
    end else if (ena) begin
      case (cmd)
        CMD_IDLE: ;
        CMD_LOAD: begin
          // Bytes shift in from the top. After four loads, the first byte
          // sits at the bottom and holds weights 0..3.
          wreg <= {ui_in, wreg[31:8]};
          ptr  <= '0;
        end
        CMD_ACC: begin
          acc <= acc_next;
          ptr <= ptr + 4'd1;  // wraps 15 -> 0; advances on zero weights too
        end
        CMD_CLEAR: begin
          acc <= '0;
          ptr <= '0;
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = acc[7:0];
  assign uio_out = {acc[13:8], 2'b00};
  assign uio_oe  = 8'hFC;

endmodule

// File: tb/tb_rejunity_ternary_dot.sv
// tb_rejunity_ternary_dot
//   Directed bench for rejunity_ternary_dot. Each step drives one cycle of
//   stimulus. A small integer model pushes the expected outputs to a
//   scoreboard queue. After the edge, the entry is popped and compared.
//   Headline results are also compared against fixed constants. These use the
//   host's 16-bit sign-extended decode of the outputs.
module tb_rejunity_ternary_dot;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  rejunity_ternary_dot dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] ACC   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
  } out_t;

  out_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: plain integers, weights held as -1/0/+1.
  int m_acc;
  int m_ptr;
  int m_w[16];

  function automatic int wdec(input logic [1:0] b);
    if (b == 2'b01) return 1;
    if (b == 2'b11) return -1;
    return 0;
  endfunction

  task automatic model_update(input logic r, input logic e, input logic [1:0] c,
                              input logic [7:0] d);
    int x;
    int s;
    if (r) begin
      m_acc = 0;
      m_ptr = 0;
      for (int i = 0; i < 16; i++) m_w[i] = 0;
    end else if (e) begin
      case (c)
        LOAD: begin
          for (int i = 0; i < 12; i++) m_w[i] = m_w[i+4];
          m_w[12] = wdec(d[1:0]);
          m_w[13] = wdec(d[3:2]);
          m_w[14] = wdec(d[5:4]);
          m_w[15] = wdec(d[7:6]);
          m_ptr = 0;
        end
        ACC: begin
          x = int'(d);
          if (d[7]) x = x - 256;
          s = m_acc + m_w[m_ptr] * x;
`ifdef TERNARY_DOT_SATURATE_EN
          if (s > 8191)  s = 8191;
          if (s < -8192) s = -8192;
`else
          s = (((s + 8192) % 16384) + 16384) % 16384 - 8192;
`endif
          m_acc = s;
          m_ptr = (m_ptr + 1) % 16;
        end
        CLEAR: begin
          m_acc = 0;
          m_ptr = 0;
        end
        default: ;
      endcase
    end
  endtask

  function automatic out_t model_out();
    logic [13:0] a;
    out_t o;
    a     = m_acc[13:0];
    o.uo  = a[7:0];
    o.uio = {a[13:8], 2'b00};
    o.oe  = 8'hFC;
    return o;
  endfunction

  // One clock of stimulus, with a scoreboard check after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] c,
                      input logic [7:0] d);
    out_t got;
    out_t exp;
    @(negedge clk);
    rst    = r;
    ena    = e;
    ui_in  = d;
    uio_in = {6'($urandom), c};
    model_update(r, e, c, d);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    got = '{uo: uo_out, uio: uio_out, oe: uio_oe};
    exp = sb.pop_front();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL step: cmd=%b ui=%h got uo/uio/oe=%h want %h", c, d, got, exp);
    end
  endtask

  task automatic run(input logic [1:0] c, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, c, d);
  endtask

  // Checks the host-decoded 16-bit result against a fixed constant.
  task automatic check_result(input string tag, input int want);
    logic [15:0] got;
    logic [15:0] exp;
    got = {{3{uio_out[7]}}, uio_out[6:2], uo_out};
    exp = 16'(want);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset, including with ena low: reset takes priority.
    step(1'b1, 1'b0, ACC, 8'h7F);
    step(1'b1, 1'b1, LOAD, 8'h55);
    check_result("reset", 0);

    // Weights are all zero after reset, so ACC leaves acc at zero.
    run(ACC, 8'h7F, 5);
    check_result("zero_weights", 0);

    // All +1 weights, 100 x16 -> 1600.
    run(LOAD, 8'h55, 4);
    run(ACC, 8'd100, 16);
    check_result("plus_1600", 1600);
    vectors++;
    assert ({uo_out, uio_out} === 16'h4018) else begin
      miscompares++;
      $error("FAIL raw_1600: got %h want 4018", {uo_out, uio_out});
    end

    // All -1 weights; LOAD leaves acc alone and CLEAR zeroes it.
    run(LOAD, 8'hFF, 4);
    check_result("load_keeps_acc", 1600);
    run(CLEAR, 8'h00, 1);
    run(ACC, 8'h80, 16);
    check_result("minus_2048", 2048);

    // Sparse weights: w0=+1, w4=-1. Then wrap back to w0.
    run(LOAD, 8'h01, 1);
    run(LOAD, 8'h03, 1);
    run(LOAD, 8'h00, 2);
    run(CLEAR, 8'h00, 1);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, ACC, 8'(k + 1));
    check_result("sparse_m4", -4);
    run(ACC, 8'd10, 1);
    check_result("ptr_wrap", 6);

    // 65 x 127 with +1 weights overflows 14 bits.
    run(LOAD, 8'h55, 4);
    run(CLEAR, 8'h00, 1);
    run(ACC, 8'h7F, 65);
`ifdef TERNARY_DOT_SATURATE_EN
    check_result("overflow", 8191);
`else
    check_result("overflow", -8129);
`endif

    // ena low holds acc and ptr whatever the command; resuming continues.
    run(LOAD, 8'h01, 1);
    run(LOAD, 8'h03, 1);
    run(LOAD, 8'h00, 2);
    run(CLEAR, 8'h00, 1);
    run(ACC, 8'd1, 3);
    step(1'b0, 1'b0, ACC, 8'd50);
    step(1'b0, 1'b0, CLEAR, 8'd50);
    step(1'b0, 1'b0, LOAD, 8'hFF);
    check_result("ena_hold", 1);
    run(ACC, 8'd7, 2);
    check_result("ena_resume", -6);
    run(IDLE, 8'hAA, 2);
    check_result("idle_hold", -6);

    // Mid-stream reset clears acc, ptr and weights.
    run(LOAD, 8'h55, 4);
    run(CLEAR, 8'h00, 1);
    run(ACC, 8'd20, 3);
    check_result("pre_reset", 60);
    step(1'b1, 1'b0, ACC, 8'd20);
    check_result("mid_reset", 0);
    run(ACC, 8'h7F, 2);
    check_result("weights_cleared", 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
